// File: rtl/incoming_port_handler.sv
// Receive side of one router link: buffers inbound packets, XY-routes the head
// packet and holds it in an output register until its target accepts it.
module incoming_port_handler #(
  parameter int unsigned NETWORK_ADDRESS_WIDTH    = 4,
  parameter int unsigned CACHE_BANK_ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH               = 32,
  parameter int unsigned BUFFER_DEPTH             = 4,
  parameter int unsigned LOCAL_X                  = 1,
  parameter int unsigned LOCAL_Y                  = 1
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]                    requesterAddressIn,
  input  logic                                                readIn,
  input  logic                                                writeIn,
  input  logic [DATA_WIDTH-1:0]                               dataIn,
  output logic                                                bufferFull,
  input  logic                                                stall_NORTH,
  input  logic                                                stall_SOUTH,
  input  logic                                                stall_EAST,
  input  logic                                                stall_WEST,
  input  logic                                                stall_LOCAL,
  output logic                                                selectBit_NORTH,
  output logic                                                selectBit_SOUTH,
  output logic                                                selectBit_EAST,
  output logic                                                selectBit_WEST,
  output logic                                                selectBit_LOCAL,
  output logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]                    requesterAddressOut,
  output logic                                                readOut,
  output logic                                                writeOut,
  output logic [DATA_WIDTH-1:0]                               dataOut,
  output logic [7:0]                                          errorCount
);

  localparam int unsigned NAW  = NETWORK_ADDRESS_WIDTH;
  localparam int unsigned CBAW = CACHE_BANK_ADDRESS_WIDTH;
  localparam int unsigned DAW  = NAW + CBAW;
  localparam int unsigned HW   = NAW / 2;
  localparam int unsigned PTRW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam int unsigned NTGT = 5;

  // One-hot target bit positions
  localparam int unsigned T_NORTH = 0;
  localparam int unsigned T_SOUTH = 1;
  localparam int unsigned T_EAST  = 2;
  localparam int unsigned T_WEST  = 3;
  localparam int unsigned T_LOCAL = 4;

  typedef struct packed {
    logic [DAW-1:0]        dest;
    logic [NAW-1:0]        req;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] data;
  } packet_t;

  packet_t          mem [BUFFER_DEPTH];
  logic [PTRW-1:0]  wrPtr, rdPtr;
  logic [CNTW-1:0]  count;
  logic [NTGT-1:0]  selectReg;

  packet_t          inPkt, headPkt;
  logic             inValid, malformed, enq, dropEvt;
  logic             outValid, releaseOut, load;
  logic [NTGT-1:0]  stallVec, routeSel;
  logic [HW-1:0]    dx, dy;
  logic [CNTW-1:0]  countNext;

  // Admission, release and load decisions from registered state only
  always_comb begin
    inPkt      = '{dest: destinationAddressIn, req: requesterAddressIn,
                   read: readIn, write: writeIn, data: dataIn};
    headPkt    = mem[rdPtr];
    inValid    = readIn ^ writeIn;
    malformed  = readIn & writeIn;
    enq        = inValid && (count < CNTW'(BUFFER_DEPTH));
    dropEvt    = malformed || (inValid && !enq);
    stallVec   = {stall_LOCAL, stall_WEST, stall_EAST, stall_SOUTH, stall_NORTH};
    outValid   = |selectReg;
    releaseOut = |(selectReg & ~stallVec);
    load       = (count != '0) && (!outValid || releaseOut);
    countNext  = count + CNTW'(enq) - CNTW'(load);
  end

  // XY routing: resolve X first, then Y, otherwise deliver locally
  always_comb begin
    dx       = headPkt.dest[CBAW +: HW];
    dy       = headPkt.dest[CBAW + HW +: HW];
    routeSel = '0;
    if (dx > HW'(LOCAL_X))      routeSel[T_EAST]  = 1'b1;
    else if (dx < HW'(LOCAL_X)) routeSel[T_WEST]  = 1'b1;
    else if (dy > HW'(LOCAL_Y)) routeSel[T_SOUTH] = 1'b1;
    else if (dy < HW'(LOCAL_Y)) routeSel[T_NORTH] = 1'b1;
    else                        routeSel[T_LOCAL] = 1'b1;
  end

  // Packet storage carries no reset; validity lives in the pointers/count
  always_ff @(posedge clk) begin
    if (enq) mem[wrPtr] <= inPkt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      bufferFull <= 1'b0;
      errorCount <= '0;
    end else begin
      if (enq)  wrPtr <= wrPtr + PTRW'(1);
      if (load) rdPtr <= rdPtr + PTRW'(1);
      count      <= countNext;
      bufferFull <= (countNext == CNTW'(BUFFER_DEPTH));
      if (dropEvt && (errorCount != 8'hFF)) errorCount <= errorCount + 8'd1;
    end
  end

  // Output register; address/data keep their last value when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      selectReg             <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      destinationAddressOut <= '0;
      requesterAddressOut   <= '0;
      dataOut               <= '0;
    end else if (load) begin
      selectReg             <= routeSel;
      readOut               <= headPkt.read;
      writeOut              <= headPkt.write;
      destinationAddressOut <= headPkt.dest;
      requesterAddressOut   <= headPkt.req;
      dataOut               <= headPkt.data;
    end else if (releaseOut) begin
      selectReg <= '0;
      readOut   <= 1'b0;
      writeOut  <= 1'b0;
    end
  end

  assign selectBit_NORTH = selectReg[T_NORTH];
  assign selectBit_SOUTH = selectReg[T_SOUTH];
  assign selectBit_EAST  = selectReg[T_EAST];
  assign selectBit_WEST  = selectReg[T_WEST];
  assign selectBit_LOCAL = selectReg[T_LOCAL];

endmodule

// File: tb/tb_incoming_port_handler.sv
// Randomized bench for incoming_port_handler: a queue-based reference model
// predicts admissions and drops; a negedge monitor checks every presentation.
module tb_incoming_port_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] destinationAddressIn;
  logic [3:0]  requesterAddressIn;
  logic        readIn, writeIn;
  logic [31:0] dataIn;
  logic        bufferFull;
  logic        stall_NORTH, stall_SOUTH, stall_EAST, stall_WEST, stall_LOCAL;
  logic        selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL;
  logic [11:0] destinationAddressOut;
  logic [3:0]  requesterAddressOut;
  logic        readOut, writeOut;
  logic [31:0] dataOut;
  logic [7:0]  errorCount;

  incoming_port_handler dut (
    .clk(clk), .reset(reset),
    .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
    .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn), .bufferFull(bufferFull),
    .stall_NORTH(stall_NORTH), .stall_SOUTH(stall_SOUTH), .stall_EAST(stall_EAST),
    .stall_WEST(stall_WEST), .stall_LOCAL(stall_LOCAL),
    .selectBit_NORTH(selectBit_NORTH), .selectBit_SOUTH(selectBit_SOUTH),
    .selectBit_EAST(selectBit_EAST), .selectBit_WEST(selectBit_WEST),
    .selectBit_LOCAL(selectBit_LOCAL),
    .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
    .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut), .errorCount(errorCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] dest;
    logic [3:0]  req;
    logic        rd;
    logic        wr;
    logic [31:0] data;
  } pkt_t;

  pkt_t fifoQ[$];
  pkt_t expQ[$];
  bit   mHold;
  int   mTgt;
  int   mErr;
  int   tests = 0;
  int   fails = 0;
  bit   started = 1'b0;

  // Target index: 0 N, 1 S, 2 E, 3 W, 4 LOCAL; this router sits at (1,1)
  function automatic int routeOf(logic [11:0] d);
    int dx, dy;
    dx = int'(d[9:8]);
    dy = int'(d[11:10]);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 1;
    if (dy < 1) return 0;
    return 4;
  endfunction

  function automatic bit stallOf(int t);
    case (t)
      0: return stall_NORTH;
      1: return stall_SOUTH;
      2: return stall_EAST;
      3: return stall_WEST;
      default: return stall_LOCAL;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet queue plus a single held slot
  bit   mRel, mLd, mAcc, mV;
  pkt_t mP;
  always @(posedge clk) begin
    if (reset) begin
      fifoQ.delete();
      expQ.delete();
      mHold = 1'b0;
      mErr  = 0;
    end else begin
      mRel = mHold && !stallOf(mTgt);
      mLd  = (fifoQ.size() > 0) && (!mHold || mRel);
      mV   = readIn ^ writeIn;
      mAcc = mV && (fifoQ.size() < 4);
      if ((readIn && writeIn) || (mV && !mAcc))
        if (mErr < 255) mErr++;
      if (mLd) begin
        mP    = fifoQ.pop_front();
        mTgt  = routeOf(mP.dest);
        mHold = 1'b1;
      end else if (mRel) begin
        mHold = 1'b0;
      end
      if (mAcc) begin
        mP = '{dest: destinationAddressIn, req: requesterAddressIn,
               rd: readIn, wr: writeIn, data: dataIn};
        fifoQ.push_back(mP);
        expQ.push_back(mP);
      end
    end
  end

  // Monitor: pops the scoreboard on each new presentation, checks stability while held
  logic [4:0] sel;
  bit         newPres = 1'b1;
  pkt_t       cur, prev, e;
  int         tIdx;
  always @(negedge clk) begin
    if (started) begin
      sel = {selectBit_LOCAL, selectBit_WEST, selectBit_EAST, selectBit_SOUTH, selectBit_NORTH};
      cur = '{dest: destinationAddressOut, req: requesterAddressOut,
              rd: readOut, wr: writeOut, data: dataOut};
      chk("bufferFull", 64'(bufferFull), 64'(fifoQ.size() == 4));
      chk("errorCount", 64'(errorCount), 64'(mErr));
      chk("outValid", 64'(sel != 0), 64'(mHold));
      if (sel != 0) begin
        chk("oneHot", 64'($countones(sel)), 64'd1);
        tIdx = 0;
        for (int i = 0; i < 5; i++) if (sel[i]) tIdx = i;
        if (newPres) begin
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpectedPacket: select %b with empty scoreboard at %0t", sel, $time);
          end else begin
            e = expQ.pop_front();
            chk("target", 64'(sel), 64'(5'b1 << routeOf(e.dest)));
            chk("dest", 64'(cur.dest), 64'(e.dest));
            chk("req", 64'(cur.req), 64'(e.req));
            chk("read", 64'(cur.rd), 64'(e.rd));
            chk("write", 64'(cur.wr), 64'(e.wr));
            chk("data", 64'(cur.data), 64'(e.data));
          end
        end else begin
          chk("heldFields", 64'(cur), 64'(prev));
        end
        prev    = cur;
        newPres = !stallOf(tIdx);
      end else begin
        chk("idleRdWr", 64'({readOut, writeOut}), 64'd0);
        newPres = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(int y, int x, int bank, bit rd, bit wr, logic [31:0] d);
    destinationAddressIn = {2'(y), 2'(x), 8'(bank)};
    requesterAddressIn   = 4'($urandom);
    readIn  = rd;
    writeIn = wr;
    dataIn  = d;
    tick();
    readIn  = 1'b0;
    writeIn = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {readIn, writeIn} = 2'b00;
    destinationAddressIn = '0;
    requesterAddressIn   = '0;
    dataIn = '0;
    {stall_NORTH, stall_SOUTH, stall_EAST, stall_WEST, stall_LOCAL} = 5'b0;
    tick();
    started = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);

    // Single write heading east
    send(1, 3, 8'h2A, 1'b0, 1'b1, 32'hDEADBEEF);
    idle(3);

    // West, east, north, local back to back
    send(1, 0, 1, 1'b1, 1'b0, 32'h1111_0000);
    send(1, 2, 2, 1'b0, 1'b1, 32'h2222_0000);
    send(0, 1, 3, 1'b1, 1'b0, 32'h3333_0000);
    send(1, 1, 4, 1'b0, 1'b1, 32'h4444_0000);
    idle(4);

    // South stalled: fill the FIFO, overflow once, then drain
    stall_SOUTH = 1'b1;
    send(3, 1, 5, 1'b0, 1'b1, 32'h5555_0000);
    for (int i = 0; i < 5; i++) send(i % 4, (i + 1) % 4, i, 1'b1, 1'b0, 32'h6000_0000 + 32'(i));
    idle(3);
    stall_SOUTH = 1'b0;
    idle(8);

    // Malformed packet
    send(1, 2, 6, 1'b1, 1'b1, 32'hBAD0_BAD0);
    idle(2);

    // Ten eastbound packets under an alternating east stall
    for (int i = 0; i < 10; i++) begin
      stall_EAST = 1'(i);
      send(2, 2, i, 1'b0, 1'b1, 32'h7000_0000 + 32'(i));
    end
    stall_EAST = 1'b0;
    idle(10);

    // Reset with a stalled head and three queued packets
    stall_WEST = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 0, i, 1'b1, 1'b0, 32'h8000_0000 + 32'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall_WEST = 1'b0;
    idle(6);

    // Random traffic with random stalls, occasional malformed or overflow sends
    for (int c = 0; c < 400; c++) begin
      stall_NORTH = ($urandom_range(0, 3) == 0);
      stall_SOUTH = ($urandom_range(0, 3) == 0);
      stall_EAST  = ($urandom_range(0, 3) == 0);
      stall_WEST  = ($urandom_range(0, 3) == 0);
      stall_LOCAL = ($urandom_range(0, 3) == 0);
      destinationAddressIn = 12'($urandom);
      requesterAddressIn   = 4'($urandom);
      dataIn = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        readIn = 1'b1; writeIn = 1'b1;
      end else if ($urandom_range(0, 9) < 7) begin
        readIn = 1'($urandom); writeIn = ~readIn;
      end else begin
        readIn = 1'b0; writeIn = 1'b0;
      end
      tick();
    end
    {readIn, writeIn} = 2'b00;
    {stall_NORTH, stall_SOUTH, stall_EAST, stall_WEST, stall_LOCAL} = 5'b0;
    idle(20);
    chk("drained", 64'(expQ.size()), 64'd0);
    chk("finalIdle", 64'(mHold), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/incoming_port_handler.md
Name: incoming_port_handler

Overview:
Receive side of one router link (N/S/E/W). Buffers packets arriving from the neighbouring router in a FIFO and decodes each head packet's destination with XY routing. Raises exactly one select bit toward the matching output port arbiter, or toward the local cache, and holds the packet until that target is not stalled. Drives the selectBit_* / destinationAddress / requesterAddress / read / write / data fields consumed by the output port arbiters.

Parameters:
NETWORK_ADDRESS_WIDTH, 4, network node address; upper half = Y, lower half = X; must be even.
CACHE_BANK_ADDRESS_WIDTH, 8, bank address within a node, low bits of destination address.
DATA_WIDTH, 32, payload width.
BUFFER_DEPTH, 4, FIFO entries; power of two, >= 2.
LOCAL_X, 1, this router's X coordinate.
LOCAL_Y, 1, this router's Y coordinate.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
destinationAddressIn  in  NAW+CBAW  inbound destination {Y,X,bank}.
requesterAddressIn  in  NAW  inbound requester node.
readIn  in  1  inbound read packet.
writeIn  in  1  inbound write packet.
dataIn  in  DATA_WIDTH  inbound payload.
bufferFull  out  1  to upstream; upstream must not send while high.
stall_NORTH, stall_SOUTH, stall_EAST, stall_WEST, stall_LOCAL  in  1 each  target cannot accept this cycle.
selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL  out  1 each  one-hot forward request.
destinationAddressOut  out  NAW+CBAW  held packet destination.
requesterAddressOut  out  NAW  held packet requester.
readOut  out  1  held packet is a read; gated by valid.
writeOut  out  1  held packet is a write; gated by valid.
dataOut  out  DATA_WIDTH  held payload.
errorCount  out  8  saturating count of dropped packets.

Behaviour:
- Reset: FIFO pointers and count to 0; outValid to 0; all selectBit_*, readOut, writeOut, bufferFull to 0; address and data outputs to 0; errorCount to 0. Reset asserted mid-operation flushes the FIFO and the output register, and no packet survives it.
- Inbound valid = readIn XOR writeIn. readIn & writeIn both high counts as malformed: dropped, errorCount +1.
- Enqueue at posedge when valid and count < BUFFER_DEPTH. The registered count is used; there is no same-cycle bypass of a full FIFO.
- Valid packet while full (upstream violation): dropped, errorCount +1. errorCount saturates at 255.
- bufferFull = (count == BUFFER_DEPTH), derived from registered count.
- Pointers are log2(BUFFER_DEPTH) bits and wrap naturally. Simultaneous enqueue and dequeue leaves count unchanged.
- Output stage is a single register holding {packet, target, outValid}.
- Release condition: outValid & ~stall_<target>.
- Load condition: FIFO non-empty & (~outValid | release). The head is popped into the output register at that posedge.
- Release without load clears outValid.
- While stalled, every output field holds stable.
- Routing on the head packet, using dx = dest X and dy = dest Y:
  - dx > LOCAL_X gives EAST; dx < LOCAL_X gives WEST.
  - Otherwise dy > LOCAL_Y gives SOUTH; dy < LOCAL_Y gives NORTH.
  - Otherwise LOCAL.
  - Comparisons are unsigned, NAW/2 bits.
- selectBit_<T> = outValid & (target == T); never more than one high. readOut and writeOut are ANDed with outValid. Address and data outputs hold their last value when idle.
- Latency: a packet accepted at posedge t into an empty handler with idle output appears on outputs after posedge t+1.
- Throughput: 1 packet/cycle with no stall.
- Stall on one target blocks the whole queue (no bypass, head-of-line blocking by design).

Test Plan:
1. Reset, then one write with dest {Y=1,X=3,bank=0x2A} and data 0xDEADBEEF -> after posedge t+1: selectBit_EAST=1, writeOut=1, dataOut=0xDEADBEEF; next cycle all selects 0.
2. Four back-to-back packets to X=0, X=2, (X=1,Y=0), (X=1,Y=1), no stall -> selects WEST, EAST, NORTH, LOCAL on consecutive cycles, each 1 cycle.
3. stall_SOUTH=1 while a (X=1,Y=3) packet is held and 4 more packets are sent -> selectBit_SOUTH held with fields stable, FIFO fills, bufferFull=1. Fifth extra packet is dropped, errorCount=1. Release stall -> 4 queued packets drain in order.
4. readIn=writeIn=1 -> nothing enqueued, no select, errorCount increments.
5. Continuous traffic for 10 packets with alternating stall_EAST -> FIFO pointers wrap, order preserved, no loss.
6. reset asserted while FIFO holds 3 packets and output is stalled -> next cycle all selects 0, bufferFull=0; after reset deasserts no stale packet emerges.
